// File: rtl/min_index_writeback.sv
// Arg-min writeback stage: registers the min-finder result, encodes the winner mask to an
// index, and presents it downstream over valid/ready with a per-channel write enable.
module min_index_writeback #(
   parameter int DATA_WIDTH    = 8,
   parameter int CHANNEL_COUNT = 6,
   parameter int INDEX_WIDTH   = $clog2(CHANNEL_COUNT)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_result,
   input  logic [CHANNEL_COUNT-1:0] in_onehot,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_value,
   output logic [INDEX_WIDTH-1:0]   out_index,
   output logic [CHANNEL_COUNT-1:0] out_channel_enable,
   output logic                     none_valid,
   output logic                     onehot_error,
   output logic [15:0]              xfer_count
);

   typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [CHANNEL_COUNT-1:0] ONE_C  = {{(CHANNEL_COUNT-1){1'b0}}, 1'b1};
   localparam logic [CHANNEL_COUNT-1:0] ZERO_C = {CHANNEL_COUNT{1'b0}};

   // Isolates the lowest set bit so a multi-hot mask still names exactly one winner.
   function automatic logic [CHANNEL_COUNT-1:0] lowest_bit(input logic [CHANNEL_COUNT-1:0] mask);
      return mask & (~mask + ONE_C);
   endfunction

   function automatic logic [INDEX_WIDTH-1:0] encode(input logic [CHANNEL_COUNT-1:0] mask);
      logic [INDEX_WIDTH-1:0] idx;
      idx = {INDEX_WIDTH{1'b0}};
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
         if (mask[i]) begin
            idx = INDEX_WIDTH'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   state_t                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    value_q, value_d;
   logic [INDEX_WIDTH-1:0]   index_q, index_d;
   logic [CHANNEL_COUNT-1:0] enable_q, enable_d;
   logic                     none_q, none_d;
   logic                     error_q, error_d;
   logic [15:0]              count_q, count_d;

   logic                     accept_s;
   logic                     drain_s;
   logic [CHANNEL_COUNT-1:0] winner_s;
   logic                     multi_s;

   assign in_ready = (state_q == EMPTY) || out_ready;
   assign accept_s = in_valid && in_ready;
   assign drain_s  = (state_q == FULL) && out_ready;
   assign winner_s = lowest_bit(in_onehot);
   assign multi_s  = |(in_onehot & (in_onehot - ONE_C));

   // Next-state: drain first, then let an accepted nonzero mask overwrite the slot.
   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      index_d  = index_q;
      enable_d = enable_q;
      none_d   = 1'b0;
      error_d  = error_q;
      count_d  = count_q;

      if (drain_s) begin
         count_d  = count_q + 16'd1;
         state_d  = EMPTY;
         enable_d = ZERO_C;
      end else begin
         state_d = state_q;
      end

      if (accept_s) begin
         if (in_onehot == ZERO_C) begin
            none_d = 1'b1;
         end else begin
            value_d  = in_result;
            index_d  = encode(winner_s);
            enable_d = winner_s;
            state_d  = FULL;
            if (multi_s) begin
               error_d = 1'b1;
            end else begin
               error_d = error_q;
            end
         end
      end else begin
         none_d = 1'b0;
      end
   end

   // Registers for state, payload, status flags and the transfer counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= EMPTY;
         value_q  <= {DATA_WIDTH{1'b0}};
         index_q  <= {INDEX_WIDTH{1'b0}};
         enable_q <= ZERO_C;
         none_q   <= 1'b0;
         error_q  <= 1'b0;
         count_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         value_q  <= value_d;
         index_q  <= index_d;
         enable_q <= enable_d;
         none_q   <= none_d;
         error_q  <= error_d;
         count_q  <= count_d;
      end
   end

   assign out_valid          = (state_q == FULL);
   assign out_value          = value_q;
   assign out_index          = index_q;
   assign out_channel_enable = enable_q;
   assign none_valid         = none_q;
   assign onehot_error       = error_q;
   assign xfer_count         = count_q;

endmodule
